bank_rd_sched: RTL and testbench
================================

// Module: bank_rd_sched
// PURPOSE
//  Registered, three-requester read scheduler for the banked activation/weight RAM.
//  - Buffers one outstanding read per requester (i, d, c).
//  - Each cycle, issues every non-conflicting pending read on a dedicated per-requester lane.
//  - Retries conflict losers and returns a read-valid strobe after the fixed RAM latency.
//  - Sits between the requesters and the bank crossbar; replaces stateless fixed-priority grant.
// PARAMETERS
//  BANKBITS  5  bank-select bits; bank = addr[WORDBITS +: BANKBITS]
//  WORDBITS  9  word-within-bank bits; ADDRW = BANKBITS+WORDBITS
//  RDLAT     2  RAM read latency in cycles from m_en to data (>=1)
//  AGEMAX    4  wait cycles before a pending read turns urgent (>=1; aging build only)
// PORTS
//  clk       in   1      clock
//  rst       in   1      synchronous, active-high reset
//  x_req     in   1      read request, x in {i,d,c}; x_addr must be stable while x_req & ~x_rdy
//  x_addr    in   ADDRW  read address
//  x_rdy     out  1      slot free; request accepted on edge where x_req & x_rdy
//  x_rvalid  out  1      read data for x valid at RAM output this cycle
//  m_en      out  3      lane issue strobes [0]=i [1]=d [2]=c, registered
//  m_addr    out  3*ADDRW  lane addresses, lane k at [k*ADDRW +: ADDRW], registered
//  busy      out  1      any slot pending or any read in flight
// BEHAVIOUR
//  - Reset (sync): pend=0, age=0, m_en=0, m_addr=0, rvalid pipes=0, x_rdy=1, busy=0.
//    Reads in flight at reset are dropped; no x_rvalid after reset.
//  - Accept: edge N with x_req & x_rdy loads pend_x=1 and paddr_x=x_addr. x_rdy = ~pend_x (registered state).
//  - Arbitration (combinational on pend/paddr/age, cycle N+1):
//    - Priority order: urgent requesters first, then non-urgent; within a class i > d > c.
//    - Walk requesters in that order. One issues iff pending and its bank differs from every bank already chosen this cycle (greedy on issued, not on pending).
//    - Requests to the same bank but different words still conflict.
//    - Two or three distinct banks issue in the same cycle.
//  - Issue (edge ending N+1):
//    - Winners: m_en[k]=1, m_addr lane=paddr, pend cleared, age cleared.
//    - x_rdy high in N+2, so back-to-back accept gives one issue per 2 cycles per requester.
//    - Losers: pend held, age += 1, saturating at AGEMAX.
//  - m_en is high only in the cycle after a win.
//    m_addr holds its last value when m_en=0 (no toggling required).
//  - Return: x_rvalid = m_en[k] delayed RDLAT cycles (shift reg per lane). Request accepted at edge N, uncontended: m_en in N+2, rvalid in N+2+RDLAT.
//  - x_req while ~x_rdy is ignored (no error, no queueing).
//  - Simultaneous accept and issue on one requester cannot occur (rdy=0 while pending).
//  - busy = |pend | |rvalid pipes | |m_en.
// CONFIGURATION
//  - BRS_AGING_EN defined:
//    - Per-requester age counters, width $clog2(AGEMAX+1).
//    - Urgent = (age == AGEMAX).
//    - Bounds wait of any request to AGEMAX+2 cycles under continuous contention.
//  - BRS_AGING_EN undefined:
//    - No counters, nobody is urgent, pure fixed priority i > d > c.
//    - AGEMAX ignored.
//    - c may starve under sustained same-bank traffic; this is the accepted behaviour.
// STRUCTURE
//  - Package bank_rd_pkg:
//    - localparam ADDRW.
//    - Requester index constants REQ_I=0, REQ_D=1, REQ_C=2.
//    - Function bank_of(addr) returning addr[WORDBITS +: BANKBITS].
//  - Sub-module brs_slot, instantiated 3x:
//    - Holds pend/paddr, the age counter (under BRS_AGING_EN) and the RDLAT rvalid shift register.
//    - Exports pend, paddr, urgent; takes win.
//  - Top holds the ordering/greedy conflict logic and the m_en/m_addr output registers.
// TESTING (BANKBITS=5, WORDBITS=9, RDLAT=2, AGEMAX=4)
//  1. Reset: hold rst 3 cycles mid-traffic with reads in flight -> all outputs 0, rdy=1, no rvalid for 5 cycles after.
//  2. No conflict: i=0x0000, d=0x0200, c=0x0400 accepted edge 0 -> m_en=3'b111 in cycle 2, all rvalid in cycle 4.
//  3. Same bank, different word: i=0x0001, d=0x0005 edge 0 -> m_en=001 cycle 2, m_en=010 cycle 3, d_rvalid cycle 5.
//  4. Greedy: i=0x0200, d=0x0200, c=0x0400 -> cycle 2 m_en=101 (c not blocked by losing d), d issues cycle 3.
//  5. Aging on: i re-requests bank 3 every 2 cycles, c held on bank 3 -> c urgent after 4 lost cycles, issues before i; c wait <=6 cycles.
//  6. Aging off: same stimulus as 5 -> c never issues while i traffic continues; busy stays 1.

Source files
------------

// File: rtl/bank_rd_sched_pkg.sv
// Shared types, sizes and helpers for the banked-RAM read scheduler.
// Optional feature macro: BRS_AGING_EN (per-requester age counters and urgency).
package bank_rd_pkg;

  localparam int BANKBITS = 5;
  localparam int WORDBITS = 9;
  localparam int RDLAT    = 2;
  localparam int ADDRW    = BANKBITS + WORDBITS;
  localparam int NREQ     = 3;

`ifdef BRS_AGING_EN
  localparam int AGEMAX   = 4;
  localparam int AGEW     = $clog2(AGEMAX + 1);
`endif

  // Requester / lane indices: lane k of m_en and m_addr belongs to requester k.
  typedef enum int {
    REQ_I = 0,
    REQ_D = 1,
    REQ_C = 2
  } req_e;

  typedef logic [ADDRW-1:0]    addr_t;
  typedef logic [BANKBITS-1:0] bank_t;

  function automatic bank_t bank_of(input addr_t addr);
    return addr[WORDBITS +: BANKBITS];
  endfunction

endpackage

// File: rtl/bank_rd_sched_if.sv
// Requester-side and RAM-side signals of the read scheduler.
// Index k of every vector is requester k (i=0, d=1, c=2).
// Optional feature macro: BRS_AGING_EN (no effect on this interface).
interface bank_rd_sched_if;
  import bank_rd_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0][ADDRW-1:0] addr;
  logic [NREQ-1:0]            rdy;
  logic [NREQ-1:0]            rvalid;
  logic [NREQ-1:0]            m_en;
  logic [NREQ-1:0][ADDRW-1:0] m_addr;
  logic                       busy;

  // Requester / bench side.
  modport master (
    output req, addr,
    input  rdy, rvalid, m_en, m_addr, busy
  );

  // Scheduler side.
  modport slave (
    input  req, addr,
    output rdy, rvalid, m_en, m_addr, busy
  );

endinterface

// File: rtl/bank_rd_sched_slot.sv
// One requester slot: a single buffered read, its age (aging build only)
// and the read-latency pipe that turns the lane issue into rvalid.
// Optional feature macro: BRS_AGING_EN.
module brs_slot
  import bank_rd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_req,
  input  addr_t i_addr,
  input  logic  i_win,       // this slot issues at the coming edge
  input  logic  i_issued,    // registered lane strobe (m_en[k])
  output logic  o_rdy,
  output logic  o_pend,
  output addr_t o_paddr,
  output logic  o_urgent,
  output logic  o_rvalid,
  output logic  o_pipe_busy
);

  logic             r_pend;
  addr_t            r_paddr;
  logic [RDLAT-1:0] r_rv_pipe;

  // Load on accept, release on win; a pending slot never accepts.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_paddr <= '0;
    end else if (i_win) begin
      r_pend  <= 1'b0;
    end else if (i_req && !r_pend) begin
      r_pend  <= 1'b1;
      r_paddr <= i_addr;
    end
  end

`ifdef BRS_AGING_EN
  logic [AGEW-1:0] r_age;

  // Count lost arbitration cycles, saturating; cleared on win or while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (i_win || !r_pend) begin
      r_age <= '0;
    end else if (r_age != AGEW'(AGEMAX)) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign o_urgent = r_pend && (r_age == AGEW'(AGEMAX));
`else
  assign o_urgent = 1'b0;
`endif

  // Delay the lane strobe by the RAM latency; reads in flight die on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rv_pipe <= '0;
    end else begin
      r_rv_pipe[0] <= i_issued;
      for (int j = 1; j < RDLAT; j++) begin
        r_rv_pipe[j] <= r_rv_pipe[j-1];
      end
    end
  end

  assign o_rdy       = ~r_pend;
  assign o_pend      = r_pend;
  assign o_paddr     = r_paddr;
  assign o_rvalid    = r_rv_pipe[RDLAT-1];
  assign o_pipe_busy = |r_rv_pipe;

endmodule

// File: rtl/bank_rd_sched.sv
// Three-requester registered read scheduler for the banked activation/weight RAM.
// Greedy per-cycle bank-conflict arbitration: urgent requesters first, then the
// rest, i > d > c within each class; every non-conflicting read issues on its lane.
// Optional feature macro: BRS_AGING_EN (age-based urgency; otherwise fixed priority).
module bank_rd_sched
  import bank_rd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  bank_rd_sched_if.slave  bus
);

  logic [NREQ-1:0]            w_pend;
  logic [NREQ-1:0]            w_urgent;
  logic [NREQ-1:0]            w_win;
  logic [NREQ-1:0]            w_rdy;
  logic [NREQ-1:0]            w_rvalid;
  logic [NREQ-1:0]            w_pipe_busy;
  logic [NREQ-1:0][ADDRW-1:0] w_paddr;
  logic [(2**BANKBITS)-1:0]   w_bank_used;

  logic [NREQ-1:0]            r_m_en;
  logic [NREQ-1:0][ADDRW-1:0] r_m_addr;

  for (genvar k = 0; k < NREQ; k++) begin : g_slot
    brs_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_req       (bus.req[k]),
      .i_addr      (bus.addr[k]),
      .i_win       (w_win[k]),
      .i_issued    (r_m_en[k]),
      .o_rdy       (w_rdy[k]),
      .o_pend      (w_pend[k]),
      .o_paddr     (w_paddr[k]),
      .o_urgent    (w_urgent[k]),
      .o_rvalid    (w_rvalid[k]),
      .o_pipe_busy (w_pipe_busy[k])
    );
  end

  // Greedy walk: urgent pass then normal pass, lane order i,d,c; a bank is
  // claimed only by a requester that actually issues, so a loser blocks nobody.
  // NOTE: every always_comb output gets a default first, so no latch can form.
  always_comb begin
    w_win       = '0;
    w_bank_used = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_pend[k] && (w_urgent[k] == (pass == 0)) &&
            !w_bank_used[bank_of(w_paddr[k])]) begin
          w_win[k]                         = 1'b1;
          w_bank_used[bank_of(w_paddr[k])] = 1'b1;
        end
      end
    end
  end

  // Lane output registers: strobe for one cycle per win, address holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_en   <= '0;
      r_m_addr <= '0;
    end else begin
      r_m_en <= w_win;
      for (int k = 0; k < NREQ; k++) begin
        if (w_win[k]) begin
          r_m_addr[k] <= w_paddr[k];
        end
      end
    end
  end

  assign bus.rdy    = w_rdy;
  assign bus.rvalid = w_rvalid;
  assign bus.m_en   = r_m_en;
  assign bus.m_addr = r_m_addr;
  assign bus.busy   = (|w_pend) | (|w_pipe_busy) | (|r_m_en);

endmodule

// File: tb/tb_bank_rd_sched.sv
// Self-checking bench for bank_rd_sched: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based behavioural model.
// Optional feature macro: BRS_AGING_EN (bench expectations follow the same macro).
module tb_bank_rd_sched;
  import bank_rd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_rd_sched_if bus ();

  bank_rd_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_pend  [NREQ];
  addr_t      m_paddr [NREQ];
  int         m_age   [NREQ];
  addr_t      m_maddr [NREQ];
  logic [2:0] m_men;
  logic [2:0] m_hist[$];   // m_hist[j] = lane strobes j+1 cycles ago

  task automatic model_reset();
    for (int k = 0; k < NREQ; k++) begin
      m_pend[k]  = 1'b0;
      m_paddr[k] = '0;
      m_age[k]   = 0;
      m_maddr[k] = '0;
    end
    m_men = '0;
    m_hist.delete();
    for (int j = 0; j < RDLAT; j++) m_hist.push_back(3'b000);
  endtask

  function automatic bit is_urgent(input int k);
`ifdef BRS_AGING_EN
    return m_pend[k] && (m_age[k] == AGEMAX);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int         order[$];
    bank_t      taken[$];
    logic [2:0] win;
    bit         clash;
    if (rst) begin
      model_reset();
      return;
    end
    win = '0;
    for (int k = 0; k < NREQ; k++) if (is_urgent(k))  order.push_back(k);
    for (int k = 0; k < NREQ; k++) if (!is_urgent(k)) order.push_back(k);
    foreach (order[j]) begin
      if (m_pend[order[j]]) begin
        clash = 1'b0;
        foreach (taken[t]) if (taken[t] == bank_of(m_paddr[order[j]])) clash = 1'b1;
        if (!clash) begin
          win[order[j]] = 1'b1;
          taken.push_back(bank_of(m_paddr[order[j]]));
        end
      end
    end
    m_hist.push_front(m_men);
    void'(m_hist.pop_back());
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        m_pend[k]  = 1'b0;
        m_age[k]   = 0;
        m_maddr[k] = m_paddr[k];
      end else if (m_pend[k]) begin
`ifdef BRS_AGING_EN
        if (m_age[k] < AGEMAX) m_age[k]++;
`endif
      end else if (bus.req[k]) begin
        m_pend[k]  = 1'b1;
        m_paddr[k] = bus.addr[k];
      end
    end
    m_men = win;
  endtask

  task automatic compare();
    logic [2:0]                 e_rdy;
    logic                       e_busy;
    logic [NREQ-1:0][ADDRW-1:0] e_ma;
    e_busy = (m_men != 3'b000);
    for (int k = 0; k < NREQ; k++) begin
      e_rdy[k] = !m_pend[k];
      e_ma[k]  = m_maddr[k];
      if (m_pend[k]) e_busy = 1'b1;
    end
    foreach (m_hist[j]) if (m_hist[j] != 3'b000) e_busy = 1'b1;
    check("rdy",    64'(bus.rdy),    64'(e_rdy));
    check("m_en",   64'(bus.m_en),   64'(m_men));
    check("m_addr", 64'(bus.m_addr), 64'(e_ma));
    check("rvalid", 64'(bus.rvalid), 64'(m_hist[RDLAT-1]));
    check("busy",   64'(bus.busy),   64'(e_busy));
  endtask

  // Compare current state, then let one edge happen; returns #1 after the edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input addr_t a);
    bus.req[k]  = 1'b1;
    bus.addr[k] = a;
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    for (int j = 0; j < n; j++) cycle();
  endtask

  int         acc_t;
  int         c_iss;
  int         max_wait;
  int         busy_lo;
  addr_t      a_rand;

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    idle(3);

    // No conflict: three distinct banks issue together.
    set_req(REQ_I, 14'h0000); set_req(REQ_D, 14'h0200); set_req(REQ_C, 14'h0400);
    cycle();
    bus.req = '0;
    cycle();
    check("t2_men_111", 64'(bus.m_en), 64'(3'b111));
    cycle();
    cycle();
    check("t2_rv_111", 64'(bus.rvalid), 64'(3'b111));
    idle(6);

    // Same bank, different word: serialised, i first.
    set_req(REQ_I, 14'h0001); set_req(REQ_D, 14'h0005);
    cycle();
    bus.req = '0;
    cycle();
    check("t3_men_001", 64'(bus.m_en), 64'(3'b001));
    cycle();
    check("t3_men_010", 64'(bus.m_en), 64'(3'b010));
    cycle();
    check("t3_rv_i", 64'(bus.rvalid), 64'(3'b001));
    cycle();
    check("t3_rv_d", 64'(bus.rvalid), 64'(3'b010));
    idle(6);

    // Greedy on issued: losing d does not block c.
    set_req(REQ_I, 14'h0200); set_req(REQ_D, 14'h0200); set_req(REQ_C, 14'h0400);
    cycle();
    bus.req = '0;
    cycle();
    check("t4_men_101", 64'(bus.m_en), 64'(3'b101));
    cycle();
    check("t4_men_010", 64'(bus.m_en), 64'(3'b010));
    idle(6);

    // Reset with reads in flight.
    set_req(REQ_I, 14'h0000); set_req(REQ_D, 14'h0200); set_req(REQ_C, 14'h0400);
    cycle();
    bus.req = '0;
    cycle();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) cycle();
    check("rst_men",    64'(bus.m_en),   64'(0));
    check("rst_maddr",  64'(bus.m_addr), 64'(0));
    check("rst_rdy",    64'(bus.rdy),    64'(3'b111));
    check("rst_busy",   64'(bus.busy),   64'(0));
    check("rst_rvalid", 64'(bus.rvalid), 64'(0));
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      check("rst_no_rvalid", 64'(bus.rvalid), 64'(0));
    end

    // Sustained bank-3 contention: i and d alternate, c holds a request.
    set_req(REQ_I, 14'h0601); set_req(REQ_D, 14'h0602); set_req(REQ_C, 14'h0603);
    acc_t    = 0;
    c_iss    = 0;
    max_wait = 0;
    busy_lo  = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.rdy[REQ_C]) acc_t = t;
      cycle();
      if (bus.m_en[REQ_C]) begin
        c_iss++;
        if ((t + 1 - acc_t) > max_wait) max_wait = t + 1 - acc_t;
      end
      if (!bus.busy) busy_lo++;
    end
`ifdef BRS_AGING_EN
    check("aging_c_issues", 64'(c_iss > 0), 64'(1));
    check("aging_c_wait_bound", 64'(max_wait <= AGEMAX + 2), 64'(1));
`else
    check("fixed_c_starved", 64'(c_iss), 64'(0));
    check("fixed_busy_held", 64'(busy_lo), 64'(0));
`endif
    idle(8);

    // Random traffic over four banks with occasional resets.
    for (int t = 0; t < 500; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < NREQ; k++) begin
        bus.req[k] = ($urandom_range(0, 1) == 1);
        if (!m_pend[k]) begin
          a_rand      = addr_t'($urandom);
          a_rand[WORDBITS +: BANKBITS] = bank_t'($urandom_range(0, 3));
          bus.addr[k] = a_rand;
        end
      end
      cycle();
    end
    rst = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
